// File: rtl/bin2dec_pkg.sv
// Shared types and constants for the binary-to-BCD converter and its divider.
package bin2dec_pkg;

  localparam int DEC_BASE   = 10;
  localparam int DIGIT_BITS = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT1,
    WAIT_DIV,
    DONE
  } t_bin2dec_state;

  typedef enum logic [1:0] {
    DIV_READY,
    DIV_CHECK,
    DIV_SUB
  } t_div_state;

  // True when DIGITS decimal digits can represent every BITS-wide unsigned value.
  function automatic bit digits_fit(input int bits, input int digits);
    longint unsigned pow10;
    longint unsigned max_val;
    pow10   = 1;
    max_val = (64'd1 << bits) - 64'd1;
    for (int i = 0; i < digits; i++) pow10 = pow10 * DEC_BASE;
    return pow10 > max_val;
  endfunction

endpackage

// File: rtl/bin2dec_divider.sv
// Unsigned divider by repeated subtraction: two cycles per quotient step.
// out_finished is high while idle and holds the last quotient/remainder.
module divider
  import bin2dec_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_start,
  input  logic [BITS-1:0] in_a,
  input  logic [BITS-1:0] in_b,
  output logic [BITS-1:0] out_quot,
  output logic [BITS-1:0] out_rem,
  output logic            out_finished
);

  t_div_state      state, state_next;
  logic [BITS-1:0] rem_reg, quot_reg, b_reg;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state <= DIV_READY;
    else        state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      DIV_READY: if (in_start) state_next = DIV_CHECK;
      DIV_CHECK: begin
        if (b_reg == '0 || rem_reg < b_reg) state_next = DIV_READY;
        else                                state_next = DIV_SUB;
      end
      DIV_SUB:   state_next = DIV_CHECK;
      default:   state_next = DIV_READY;
    endcase
  end

  always_comb begin
    out_finished = (state == DIV_READY);
    out_quot     = quot_reg;
    out_rem      = rem_reg;
  end

  // Division by zero saturates the quotient and returns the dividend as remainder.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rem_reg  <= '0;
      quot_reg <= '0;
      b_reg    <= '0;
    end else begin
      unique case (state)
        DIV_READY: begin
          if (in_start) begin
            rem_reg  <= in_a;
            quot_reg <= '0;
            b_reg    <= in_b;
          end
        end
        DIV_CHECK: if (b_reg == '0) quot_reg <= '1;
        DIV_SUB: begin
          rem_reg  <= rem_reg - b_reg;
          quot_reg <= quot_reg + BITS'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bin2dec.sv
// Sequential binary-to-BCD converter: repeated division by ten, one packed
// BCD digit collected per division, least significant digit first.
module bin2dec
  import bin2dec_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int DIGITS = 3
) (
  input  logic                           in_clk,
  input  logic                           in_rst,
  input  logic                           in_start,
  input  logic [BITS-1:0]                in_val,
  output logic [DIGIT_BITS*DIGITS-1:0]   out_digits,
  output logic [$clog2(DIGITS+1)-1:0]    out_num_digits,
  output logic                           out_busy,
  output logic                           out_finished
);

  localparam int CW = $clog2(DIGITS + 1);

  if (!digits_fit(BITS, DIGITS)) begin : g_bad_params
    $error("bin2dec: DIGITS too small to hold every BITS-wide value");
  end

  t_bin2dec_state               state, state_next;
  logic [BITS-1:0]              val_reg, val_next;
  logic [DIGIT_BITS*DIGITS-1:0] digits, digits_next;
  logic [CW-1:0]                count, count_next;

  logic            div_start, div_finished;
  logic [BITS-1:0] div_a, div_b, div_quot, div_rem;
  logic            unused_rem_hi;

  // Operands come straight from registers, so they stay stable until the divider finishes.
  assign div_a = val_reg;
  assign div_b = BITS'(DEC_BASE);
  // Remainder is always below ten; the upper bits carry no information.
  assign unused_rem_hi = ^div_rem[BITS-1:DIGIT_BITS];

  divider #(.BITS(BITS)) u_divider (
    .in_clk       (in_clk),
    .in_rst       (in_rst),
    .in_start     (div_start),
    .in_a         (div_a),
    .in_b         (div_b),
    .out_quot     (div_quot),
    .out_rem      (div_rem),
    .out_finished (div_finished)
  );

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state   <= IDLE;
      val_reg <= '0;
      digits  <= '0;
      count   <= '0;
    end else begin
      state   <= state_next;
      val_reg <= val_next;
      digits  <= digits_next;
      count   <= count_next;
    end
  end

  always_comb begin
    state_next  = state;
    val_next    = val_reg;
    digits_next = digits;
    count_next  = count;
    div_start   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (in_start) begin
          val_next    = in_val;
          digits_next = '0;
          count_next  = '0;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        if (div_finished) begin
          div_start  = 1'b1;
          state_next = WAIT1;
        end
      end
      // Gives the divider one cycle to drop out_finished before it is watched again.
      WAIT1: state_next = WAIT_DIV;
      WAIT_DIV: begin
        if (div_finished) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (count == CW'(i))
              digits_next[i*DIGIT_BITS +: DIGIT_BITS] = div_rem[DIGIT_BITS-1:0];
          end
          count_next = count + CW'(1);
          val_next   = div_quot;
          state_next = (div_quot == '0) ? DONE : ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_digits     = digits;
  assign out_num_digits = count;
  assign out_busy       = (state == ISSUE) || (state == WAIT1) || (state == WAIT_DIV);
  assign out_finished   = (state == DONE);

endmodule

// File: tb/tb_bin2dec.sv
// Directed bench for bin2dec: an 8-bit/3-digit and a 16-bit/5-digit instance,
// expected BCD results queued at start and compared when the DUT reports done.
module tb_bin2dec;

  localparam int BUDGET = 20000;

  typedef struct {
    logic [19:0] digits;
    int          num;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_start = 1'b0;
  logic [7:0]  a_val   = '0;
  logic [11:0] a_digits;
  logic [1:0]  a_num;
  logic        a_busy, a_fin;

  logic        b_start = 1'b0;
  logic [15:0] b_val   = '0;
  logic [19:0] b_digits;
  logic [2:0]  b_num;
  logic        b_busy, b_fin;

  bin2dec #(.BITS(8), .DIGITS(3)) dut_a (
    .in_clk(clk), .in_rst(rst), .in_start(a_start), .in_val(a_val),
    .out_digits(a_digits), .out_num_digits(a_num), .out_busy(a_busy), .out_finished(a_fin)
  );

  bin2dec #(.BITS(16), .DIGITS(5)) dut_b (
    .in_clk(clk), .in_rst(rst), .in_start(b_start), .in_val(b_val),
    .out_digits(b_digits), .out_num_digits(b_num), .out_busy(b_busy), .out_finished(b_fin)
  );

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  function automatic exp_t model(input int v);
    exp_t e;
    e.digits = '0;
    e.num    = 0;
    do begin
      e.digits[e.num*4 +: 4] = 4'(v % 10);
      v = v / 10;
      e.num++;
    end while (v != 0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_a(input logic [7:0] v);
    @(negedge clk);
    a_val   = v;
    a_start = 1'b1;
    sb_a.push_back(model(int'(v)));
    @(posedge clk);
    #1;
    a_start = 1'b0;
    check("a_accept_busy", 64'(a_busy), 64'd1);
    check("a_accept_fin", 64'(a_fin), 64'd0);
  endtask

  task automatic wait_a(input string tag);
    int   cyc = 0;
    bit   busy_ok = 1'b1;
    exp_t e;
    while (!a_fin && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (!a_fin && !a_busy) busy_ok = 1'b0;
    end
    check({tag, "_done"}, 64'(a_fin), 64'd1);
    check({tag, "_busy_until_done"}, 64'(busy_ok), 64'd1);
    e = sb_a.pop_front();
    check({tag, "_digits"}, 64'(a_digits), 64'(e.digits[11:0]));
    check({tag, "_num"}, 64'(a_num), 64'(e.num));
  endtask

  task automatic start_b(input logic [15:0] v);
    @(negedge clk);
    b_val   = v;
    b_start = 1'b1;
    sb_b.push_back(model(int'(v)));
    @(posedge clk);
    #1;
    b_start = 1'b0;
    check("b_accept_fin", 64'(b_fin), 64'd0);
  endtask

  task automatic wait_b(input string tag);
    int   cyc = 0;
    exp_t e;
    while (!b_fin && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done"}, 64'(b_fin), 64'd1);
    e = sb_b.pop_front();
    check({tag, "_digits"}, 64'(b_digits), 64'(e.digits));
    check({tag, "_num"}, 64'(b_num), 64'(e.num));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_digits", 64'(a_digits), 64'd0);
    check("rst_num", 64'(a_num), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_fin", 64'(a_fin), 64'd0);
    rst = 1'b0;

    start_a(8'd0);
    wait_a("zero");

    start_a(8'd255);
    wait_a("v255");

    start_a(8'd10);
    wait_a("v10");
    check("v10_upper_slot", 64'(a_digits[11:8]), 64'd0);

    // A start pulse mid-conversion must not disturb the captured value.
    start_a(8'd200);
    repeat (5) @(negedge clk);
    a_val   = 8'd99;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_val   = 8'd0;
    check("ignore_still_busy", 64'(a_busy), 64'd1);
    wait_a("v200");

    // Asynchronous reset in the middle of the first division of 255.
    start_a(8'd255);
    repeat (20) @(negedge clk);
    check("midrst_busy", 64'(a_busy), 64'd1);
    rst = 1'b1;
    #1;
    sb_a.delete();
    check("midrst_digits", 64'(a_digits), 64'd0);
    check("midrst_num", 64'(a_num), 64'd0);
    check("midrst_busy_clr", 64'(a_busy), 64'd0);
    check("midrst_fin", 64'(a_fin), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    start_a(8'd7);
    wait_a("v7");

    start_b(16'd65535);
    wait_b("w65535");
    start_b(16'd12345);
    wait_b("w12345");
    start_b(16'd40);
    wait_b("w40");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2dec.md
# bin2dec

Sequential binary-to-decimal converter that sits downstream of the arithmetic blocks and feeds display/UART output stages. It repeatedly divides an unsigned BITS-wide value by 10 using an instance of `divider`. Each remainder is collected as one packed BCD digit, least significant first, until the quotient reaches zero.

## Interface
Parameters:
- BITS, 8, width of the input value and of the internal divider
- DIGITS, 3, number of 4-bit BCD digit slots in the output; must satisfy 10^DIGITS > 2^BITS - 1 (elaboration-time assertion)

Ports:
- in_clk  in  1  clock, rising edge
- in_rst  in  1  reset, asynchronous, active-high
- in_start  in  1  start a conversion (level, sampled in Idle/Done)
- in_val  in  BITS  unsigned value to convert, captured when in_start is accepted
- out_digits  out  4*DIGITS  packed BCD, digit i at bits [4*i+3 : 4*i], digit 0 = units
- out_num_digits  out  $clog2(DIGITS+1)  number of significant digits, 1..DIGITS
- out_busy  out  1  conversion in progress
- out_finished  out  1  result valid, high in Done

## Operation
States, all registered:
- Idle, entered on reset.
  - in_start=1: capture in_val into val_reg, clear digits and count, go to Issue.
- Issue: wait until divider out_finished=1, then drive div_start=1 for exactly one cycle with div_a=val_reg and div_b=10, and go to Wait1.
- Wait1: one cycle, during which the divider leaves its finished state. Go to WaitDiv.
- WaitDiv: wait for divider out_finished=1, then:
  - Write digit[count] = out_rem[3:0] and increment count.
  - Load val_reg = out_quot.
  - If out_quot==0, go to Done; else go to Issue.
- Done: out_finished=1, results held. in_start=1 restarts exactly as from Idle.

Rules:
- in_start while in Issue, Wait1 or WaitDiv is ignored; the captured value is not disturbed.
- div_a and div_b are held stable from Issue until the divider finishes.
- in_val=0 yields one division: digit0=0, out_num_digits=1.
- Unused upper digit slots read 0. No leading-zero digits are counted.
- The remainder is always < 10, so the upper BITS-4 bits of out_rem are discarded.
- count never exceeds DIGITS, guaranteed by the parameter constraint.

## Timing
- Reset values: out_digits=0, out_num_digits=0, out_busy=0, out_finished=0, state=Idle, val_reg=0.
- Reset mid-conversion: all registers return to reset values immediately. The divider instance shares in_rst, and the next in_start is accepted normally.
- out_busy=1 in Issue, Wait1 and WaitDiv.
- in_start is accepted on the rising edge while in Idle/Done. out_finished drops on that same edge.
- Per digit, with quotient q: 1 Issue cycle, 1 Wait1 cycle, plus the divider's run time of about 2q+2 cycles. Total latency is bounded by the sum over all digits.
- Outputs change only on the WaitDiv→Issue/Done edges and on start/reset.

## Structure
- Package bin2dec_pkg:
  - t_bin2dec_state enum (Idle, Issue, Wait1, WaitDiv, Done)
  - localparam DEC_BASE = 10
  - localparam DIGIT_BITS = 4
- One sub-module instance: `divider` with BITS=BITS, clock and reset tied to in_clk/in_rst.
- Two processes: clocked register process, combinational next-state process.

## Test plan
- Reset, then in_val=0, in_start pulse -> out_finished=1, out_digits=12'h000, out_num_digits=1.
- in_val=255, start -> out_digits=12'h255, out_num_digits=3. Check that out_busy is high until done.
- in_val=10, start -> out_digits=12'h010, out_num_digits=2. Check that the upper slot stays 0.
- Pulse in_start with in_val=99 while a conversion of 200 is busy -> result 12'h200, count 3. Check that the busy-time start is ignored.
- Assert in_rst during WaitDiv of a 255 conversion -> all outputs 0 next cycle. Then start with 7 -> 12'h007, count 1.
- BITS=16, DIGITS=5, in_val=65535 -> out_digits=20'h65535, count 5. Two back-to-back starts from Done both produce the correct results.
